// File: rtl/id_ex_ctrl_stage.sv
// ID/EX control pipeline register with load-use / ecall interlock and an
// ecall-driven RUN -> DRAIN -> HALTED end-of-program sequencer.
module id_ex_ctrl_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic        branch,
    input  logic        mem_read,
    input  logic        mem_to_reg,
    input  logic        mem_write,
    input  logic        alu_src,
    input  logic        write_enable,
    input  logic        pc_to_reg,
    input  logic        is_ecall,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_x17,
    input  logic        ex_flush,
    output logic        ex_is_jal,
    output logic        ex_is_jalr,
    output logic        ex_branch,
    output logic        ex_mem_read,
    output logic        ex_mem_to_reg,
    output logic        ex_mem_write,
    output logic        ex_alu_src,
    output logic        ex_write_enable,
    output logic        ex_pc_to_reg,
    output logic        ex_is_ecall,
    output logic [4:0]  ex_rd,
    output logic        stall,
    output logic        halted
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [1:0]  drain_cnt_r;
    logic [1:0]  drain_cnt_nxt_s;
    logic        halted_r;
    logic [9:0]  ex_ctrl_r;
    logic [4:0]  ex_rd_r;
    logic [9:0]  id_ctrl_s;
    logic        load_use_s;
    logic        ecall_haz_s;
    logic        stall_s;
    logic        bubble_s;
    logic        halt_trig_s;

    // Register 0 is hard-wired, so a producer targeting x0 never creates a hazard.
    function automatic logic reg_match(input logic [4:0] prod_rd, input logic [4:0] src);
        return (prod_rd != 5'd0) && (prod_rd == src);
    endfunction

    assign id_ctrl_s = {is_jal, is_jalr, branch, mem_read, mem_to_reg,
                        mem_write, alu_src, write_enable, pc_to_reg, is_ecall};

    // Hazard detection against the instruction currently held in EX.
    always_comb begin
        load_use_s  = ex_ctrl_r[6] &&
                      (reg_match(ex_rd_r, id_rs1) || reg_match(ex_rd_r, id_rs2));
        ecall_haz_s = is_ecall && ex_ctrl_r[2] && (ex_rd_r == 5'd17);
    end

    // Sequencer next state plus stall/bubble decisions.
    always_comb begin
        state_nxt_s     = state_r;
        drain_cnt_nxt_s = drain_cnt_r;
        stall_s         = 1'b0;
        bubble_s        = 1'b0;
        halt_trig_s     = 1'b0;
        case (state_r)
            RUN: begin
                stall_s     = (load_use_s || ecall_haz_s) && !ex_flush;
                bubble_s    = ex_flush || stall_s;
                halt_trig_s = is_ecall && (id_x17 == 32'd10) && !stall_s && !ex_flush;
                if (halt_trig_s) begin
                    state_nxt_s     = DRAIN;
                    drain_cnt_nxt_s = 2'd2;
                end else begin
                    state_nxt_s     = RUN;
                end
            end
            DRAIN: begin
                // Flush and hazards are irrelevant while older work retires.
                stall_s  = 1'b1;
                bubble_s = 1'b1;
                if (drain_cnt_r == 2'd0) begin
                    state_nxt_s = HALTED;
                end else begin
                    drain_cnt_nxt_s = drain_cnt_r - 2'd1;
                end
            end
            HALTED: begin
                stall_s  = 1'b1;
                bubble_s = 1'b1;
            end
            default: begin
                state_nxt_s     = RUN;
                drain_cnt_nxt_s = 2'd0;
                stall_s         = 1'b1;
                bubble_s        = 1'b1;
            end
        endcase
    end

    // Sequencer state, sticky halt flag and the ID/EX pipeline register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= RUN;
            drain_cnt_r <= 2'd0;
            halted_r    <= 1'b0;
            ex_ctrl_r   <= 10'd0;
            ex_rd_r     <= 5'd0;
        end else begin
            state_r     <= state_nxt_s;
            drain_cnt_r <= drain_cnt_nxt_s;
            halted_r    <= (state_nxt_s == HALTED);
            if (bubble_s) begin
                ex_ctrl_r <= 10'd0;
                ex_rd_r   <= 5'd0;
            end else begin
                ex_ctrl_r <= id_ctrl_s;
                ex_rd_r   <= id_rd;
            end
        end
    end

    assign ex_is_jal       = ex_ctrl_r[9];
    assign ex_is_jalr      = ex_ctrl_r[8];
    assign ex_branch       = ex_ctrl_r[7];
    assign ex_mem_read     = ex_ctrl_r[6];
    assign ex_mem_to_reg   = ex_ctrl_r[5];
    assign ex_mem_write    = ex_ctrl_r[4];
    assign ex_alu_src      = ex_ctrl_r[3];
    assign ex_write_enable = ex_ctrl_r[2];
    assign ex_pc_to_reg    = ex_ctrl_r[1];
    assign ex_is_ecall     = ex_ctrl_r[0];
    assign ex_rd           = ex_rd_r;
    assign stall           = stall_s;
    assign halted          = halted_r;

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Directed-vector bench: the driver queues hand-computed expectations, a
// monitor checks stall before each edge and the registered outputs after it.
module tb_id_ex_ctrl_stage;

    // Control bundle order: jal jalr branch mem_read mem_to_reg mem_write alu_src we pc_to_reg ecall
    localparam logic [9:0] C_NONE  = 10'h000;
    localparam logic [9:0] C_LW    = 10'h06C;
    localparam logic [9:0] C_ADD   = 10'h004;
    localparam logic [9:0] C_ADDI  = 10'h00C;
    localparam logic [9:0] C_JAL   = 10'h206;
    localparam logic [9:0] C_ECALL = 10'h001;

    typedef struct {
        int         idx;
        logic       chk_stall;
        logic       stall;
        logic [9:0] ctrl;
        logic [4:0] rd;
        logic       halted;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  id_ctrl = 10'd0;
    logic [4:0]  id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
    logic [31:0] id_x17 = 32'd0;
    logic        ex_flush = 1'b0;
    logic        ex_is_jal, ex_is_jalr, ex_branch, ex_mem_read, ex_mem_to_reg;
    logic        ex_mem_write, ex_alu_src, ex_write_enable, ex_pc_to_reg, ex_is_ecall;
    logic [4:0]  ex_rd;
    logic        stall, halted;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   vec_idx = 0;

    always #5 clk = ~clk;

    id_ex_ctrl_stage dut (
        .clk(clk), .reset(reset),
        .is_jal(id_ctrl[9]), .is_jalr(id_ctrl[8]), .branch(id_ctrl[7]),
        .mem_read(id_ctrl[6]), .mem_to_reg(id_ctrl[5]), .mem_write(id_ctrl[4]),
        .alu_src(id_ctrl[3]), .write_enable(id_ctrl[2]), .pc_to_reg(id_ctrl[1]),
        .is_ecall(id_ctrl[0]),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_x17(id_x17),
        .ex_flush(ex_flush),
        .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_branch(ex_branch),
        .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
        .ex_write_enable(ex_write_enable), .ex_pc_to_reg(ex_pc_to_reg),
        .ex_is_ecall(ex_is_ecall), .ex_rd(ex_rd), .stall(stall), .halted(halted)
    );

    // Drive one cycle of inputs and queue what must be seen this cycle / after the edge.
    task automatic vec(input logic rst, input logic [9:0] c, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] x17,
                       input logic fl, input logic chk_st, input logic e_st,
                       input logic [9:0] e_ctrl, input logic [4:0] e_rd, input logic e_halt);
        exp_t e;
        @(negedge clk);
        reset = rst; id_ctrl = c; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_x17 = x17; ex_flush = fl;
        e.idx = vec_idx; e.chk_stall = chk_st; e.stall = e_st;
        e.ctrl = e_ctrl; e.rd = e_rd; e.halted = e_halt;
        sb.push_back(e);
        vec_idx++;
    endtask

    // Monitor: stall just before the edge, registered outputs just after it.
    always begin
        exp_t e;
        logic st;
        logic [9:0] act;
        @(negedge clk);
        #4;
        if (sb.size() > 0) begin
            st = stall;
            @(posedge clk);
            #1;
            e = sb.pop_front();
            act = {ex_is_jal, ex_is_jalr, ex_branch, ex_mem_read, ex_mem_to_reg,
                   ex_mem_write, ex_alu_src, ex_write_enable, ex_pc_to_reg, ex_is_ecall};
            if (e.chk_stall) begin
                n_checks++;
                if (st !== e.stall) begin
                    n_fail++;
                    $display("FAIL stall vec%0d: got %b expected %b", e.idx, st, e.stall);
                end
            end
            n_checks++;
            if (act !== e.ctrl) begin
                n_fail++;
                $display("FAIL ex_ctrl vec%0d: got %h expected %h", e.idx, act, e.ctrl);
            end
            n_checks++;
            if (ex_rd !== e.rd) begin
                n_fail++;
                $display("FAIL ex_rd vec%0d: got %0d expected %0d", e.idx, ex_rd, e.rd);
            end
            n_checks++;
            if (halted !== e.halted) begin
                n_fail++;
                $display("FAIL halted vec%0d: got %b expected %b", e.idx, halted, e.halted);
            end
        end
    end

    initial begin
        int waited;
        // reset, then check that reset leaves an idle, non-stalling stage
        vec(1'b0, C_ADD,   5'd1, 5'd2, 5'd3,  32'd0,  1'b0, 1'b0, 1'b0, C_NONE,  5'd0,  1'b0);
        vec(1'b0, C_ADD,   5'd1, 5'd2, 5'd3,  32'd0,  1'b0, 1'b1, 1'b0, C_NONE,  5'd0,  1'b0);
        // load-use: lw x5 then add using x5 -> one bubble, then add captured
        vec(1'b1, C_LW,    5'd1, 5'd0, 5'd5,  32'd0,  1'b0, 1'b1, 1'b0, C_LW,    5'd5,  1'b0);
        vec(1'b1, C_ADD,   5'd4, 5'd5, 5'd6,  32'd0,  1'b0, 1'b1, 1'b1, C_NONE,  5'd0,  1'b0);
        vec(1'b1, C_ADD,   5'd4, 5'd5, 5'd6,  32'd0,  1'b0, 1'b1, 1'b0, C_ADD,   5'd6,  1'b0);
        // load to x0 never stalls a consumer of x0
        vec(1'b1, C_LW,    5'd1, 5'd0, 5'd0,  32'd0,  1'b0, 1'b1, 1'b0, C_LW,    5'd0,  1'b0);
        vec(1'b1, C_ADD,   5'd0, 5'd0, 5'd7,  32'd0,  1'b0, 1'b1, 1'b0, C_ADD,   5'd7,  1'b0);
        // hazard suppressed by a flush; flush bubbles the ID instruction
        vec(1'b1, C_LW,    5'd1, 5'd0, 5'd9,  32'd0,  1'b0, 1'b1, 1'b0, C_LW,    5'd9,  1'b0);
        vec(1'b1, C_JAL,   5'd9, 5'd0, 5'd1,  32'd0,  1'b1, 1'b1, 1'b0, C_NONE,  5'd0,  1'b0);
        // ecall with x17 != 10 is ordinary; ecall/x17=10 under flush is squashed
        vec(1'b1, C_ECALL, 5'd0, 5'd0, 5'd0,  32'd3,  1'b0, 1'b1, 1'b0, C_ECALL, 5'd0,  1'b0);
        vec(1'b1, C_ECALL, 5'd0, 5'd0, 5'd0,  32'd10, 1'b1, 1'b1, 1'b0, C_NONE,  5'd0,  1'b0);
        vec(1'b1, C_ADD,   5'd1, 5'd2, 5'd4,  32'd0,  1'b0, 1'b1, 1'b0, C_ADD,   5'd4,  1'b0);
        // addi x17 in EX -> ecall stalls once, then triggers halt
        vec(1'b1, C_ADDI,  5'd0, 5'd0, 5'd17, 32'd0,  1'b0, 1'b1, 1'b0, C_ADDI,  5'd17, 1'b0);
        vec(1'b1, C_ECALL, 5'd0, 5'd0, 5'd0,  32'd10, 1'b0, 1'b1, 1'b1, C_NONE,  5'd0,  1'b0);
        vec(1'b1, C_ECALL, 5'd0, 5'd0, 5'd0,  32'd10, 1'b0, 1'b1, 1'b0, C_ECALL, 5'd0,  1'b0);
        // three drain cycles ignoring flush/hazard inputs, halt on the third edge
        vec(1'b1, C_ADD,   5'd0, 5'd0, 5'd8,  32'd0,  1'b1, 1'b1, 1'b1, C_NONE,  5'd0,  1'b0);
        vec(1'b1, C_ADD,   5'd0, 5'd0, 5'd8,  32'd0,  1'b0, 1'b1, 1'b1, C_NONE,  5'd0,  1'b0);
        vec(1'b1, C_ADD,   5'd0, 5'd0, 5'd8,  32'd0,  1'b0, 1'b1, 1'b1, C_NONE,  5'd0,  1'b1);
        vec(1'b1, C_ADD,   5'd0, 5'd0, 5'd8,  32'd0,  1'b0, 1'b1, 1'b1, C_NONE,  5'd0,  1'b1);
        vec(1'b1, C_ECALL, 5'd0, 5'd0, 5'd0,  32'd10, 1'b0, 1'b1, 1'b1, C_NONE,  5'd0,  1'b1);
        // reset out of HALTED, normal capture resumes
        vec(1'b0, C_ADD,   5'd0, 5'd0, 5'd8,  32'd0,  1'b0, 1'b0, 1'b0, C_NONE,  5'd0,  1'b0);
        vec(1'b1, C_ADD,   5'd0, 5'd0, 5'd8,  32'd0,  1'b0, 1'b1, 1'b0, C_ADD,   5'd8,  1'b0);
        // halt again, reset mid-drain
        vec(1'b1, C_ECALL, 5'd0, 5'd0, 5'd0,  32'd10, 1'b0, 1'b1, 1'b0, C_ECALL, 5'd0,  1'b0);
        vec(1'b1, C_ADD,   5'd0, 5'd0, 5'd8,  32'd0,  1'b0, 1'b1, 1'b1, C_NONE,  5'd0,  1'b0);
        vec(1'b0, C_ADD,   5'd0, 5'd0, 5'd8,  32'd0,  1'b0, 1'b0, 1'b0, C_NONE,  5'd0,  1'b0);
        vec(1'b1, C_JAL,   5'd0, 5'd0, 5'd1,  32'd0,  1'b0, 1'b1, 1'b0, C_JAL,   5'd1,  1'b0);
        vec(1'b1, C_ADD,   5'd1, 5'd1, 5'd2,  32'd0,  1'b0, 1'b1, 1'b0, C_ADD,   5'd2,  1'b0);

        waited = 0;
        while (sb.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", sb.size());
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
